sonar_varredura_ctrl: RTL and testbench
=======================================

// Module: sonar_varredura_ctrl
// PURPOSE
//  Parametrised sweep controller for the sonar: steps the servo through N_POSICOES positions.
//  At each position it waits for the servo to settle, takes N_AMOSTRAS distance measurements
//  and keeps the minimum. It then hands that minimum to the serial transmitter.
//  Supports one-shot or continuous ping-pong sweep, echo timeout and graceful stop.
//  Sits between the sonar top level and the measurement, servo and serial datapath units.
// PARAMETERS
//  N_POSICOES   8            servo positions per sweep (2..16)
//  N_AMOSTRAS   4            measurements per position (1..8)
//  DIST_W       12           width of distance word (3 BCD digits; BCD order == binary order)
//  T_ASSENTO    25_000_000   settle cycles after a position change (0.5 s @ 50 MHz)
//  T_TIMEOUT    1_500_000    max cycles from medir to fim_medida before timeout
// PORTS
//  clock            in   1                  system clock
//  reset            in   1                  synchronous, active-high
//  ligar            in   1                  1-cycle start pulse; also a stop request while running
//  modo_continuo    in   1                  1 = ping-pong forever; 0 = single sweep 0..N-1
//  fim_medida       in   1                  1-cycle pulse: medida valid
//  medida           in   DIST_W             distance from measurement unit
//  fim_transmissao  in   1                  1-cycle pulse: serial frame done
//  medir            out  1                  1-cycle pulse to start a measurement
//  transmitir       out  1                  1-cycle pulse to start a serial frame
//  posicao          out  $clog2(N_POSICOES) servo position index
//  distancia_min    out  DIST_W             registered minimum for current position
//  timeout          out  1                  sticky: >=1 sample at this position timed out
//  fim_posicao      out  1                  1-cycle pulse after each position's transmission
//  fim_varredura    out  1                  1-cycle pulse at end of single sweep or on stop
//  ativo            out  1                  1 while not in INICIAL
//  db_estado        out  4                  state encoding
// BEHAVIOUR
//  Reset: state INICIAL; posicao=0, direction=up, distancia_min=all-ones, all pulses 0,
//   timeout=0, ativo=0, db_estado=0. Reset wins over every other input in the same cycle.
//  States (db_estado): INICIAL 0, PREPARA 1, ASSENTA 2, MEDE 3, AGUARDA 4, ACUMULA 5,
//   TRANSMITE 6, AGUARDA_TX 7, PROXIMA 8, FIM F.
//  INICIAL --ligar--> PREPARA. PREPARA (1 cycle): sample_cnt=0, distancia_min=all-ones,
//   timeout=0, wait counter cleared -> ASSENTA.
//  ASSENTA: counts T_ASSENTO cycles, then -> MEDE.
//  MEDE: medir=1 for one cycle, timer cleared -> AGUARDA.
//  AGUARDA: on fim_medida -> ACUMULA with sample=medida. At T_TIMEOUT without fim_medida:
//   sample=all-ones, timeout<=1, -> ACUMULA. A fim_medida in the timeout cycle takes priority.
//  ACUMULA: distancia_min<=min(distancia_min, sample). sample_cnt++.
//   If sample_cnt==N_AMOSTRAS-1 -> TRANSMITE, else -> MEDE (no re-settle).
//  TRANSMITE: transmitir=1 for one cycle -> AGUARDA_TX. AGUARDA_TX: on fim_transmissao
//   -> PROXIMA. fim_medida pulses outside AGUARDA are ignored.
//  PROXIMA (1 cycle): fim_posicao=1.
//   If stop_pend or (!modo_continuo and posicao==N-1): -> FIM.
//   Otherwise: up: posicao++; at N-1 the direction flips and posicao becomes N-2.
//   Down mirrors this at 0. Then -> PREPARA. posicao never leaves 0..N-1.
//  FIM (1 cycle): fim_varredura=1, posicao<=0, direction=up, stop_pend<=0 -> INICIAL.
//  Stop: ligar seen in any state except INICIAL/FIM sets stop_pend. The current position
//   completes its measurement and transmission before FIM. ligar in INICIAL always starts.
//  modo_continuo is sampled only in PROXIMA; changing it mid-position takes effect there.
//  distancia_min and timeout stay stable from TRANSMITE until the next PREPARA.
//  Latency: medir asserted 1 + T_ASSENTO cycles after PREPARA entry.
// STRUCTURE
//  Shared package sonar_pkg: state encoding constants, DIST_W default, DIST_MAX (all-ones).
//  One sub-module, contador_m (modulo-M counter: zera, conta, fim), instantiated 3x:
//   settle, timeout and sample counters. FSM and position/direction logic stay in this file.
// TESTING
//  1 N=4, S=2, continuous. medidas 0x120 then 0x085 at each position
//    -> distancia_min=0x085; posicao 0,1,2,3,2,1,0,1; fim_posicao once per position.
//  2 single sweep, N=4 -> exactly 4 transmitir pulses; fim_varredura 1 cycle after the 4th
//    PROXIMA; then INICIAL, posicao=0, ativo=0.
//  3 no fim_medida for one sample -> medir re-issued T_TIMEOUT+2 cycles later; timeout=1.
//    If all samples at a position time out, distancia_min=0xFFF.
//  4 ligar pulse during AGUARDA at posicao=2 -> that position still transmits;
//    next state PROXIMA then FIM; posicao not advanced; fim_varredura pulses.
//  5 reset asserted during AGUARDA_TX -> next cycle: all outputs at reset values;
//    a late fim_transmissao is ignored.
//  6 fim_medida in the exact timeout cycle -> sample=medida and timeout stays 0.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep controller: state encoding and distance defaults.
package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARA    = 4'h1,
        ASSENTA    = 4'h2,
        MEDE       = 4'h3,
        AGUARDA    = 4'h4,
        ACUMULA    = 4'h5,
        TRANSMITE  = 4'h6,
        AGUARDA_TX = 4'h7,
        PROXIMA    = 4'h8,
        FIM        = 4'hF
    } estado_t;

    localparam int DIST_W_PADRAO = 12;
    localparam logic [DIST_W_PADRAO-1:0] DIST_MAX = '1;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter: synchronous clear, count enable, and a flag on the last count value.
module contador_m #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] q;

    // Wraps to zero after the last value so the next phase starts clean even without a clear.
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            q <= '0;
        end else if (conta) begin
            q <= fim ? '0 : q + W'(1);
        end
    end

    assign fim = (q == ULTIMO);

endmodule

// File: rtl/sonar_varredura_ctrl.sv
// Sonar sweep controller: steps the servo, keeps the minimum of several samples per
// position, hands it to the serial transmitter, and handles timeouts and stop requests.
module sonar_varredura_ctrl
    import sonar_pkg::*;
#(
    parameter int N_POSICOES = 8,
    parameter int N_AMOSTRAS = 4,
    parameter int DIST_W     = DIST_W_PADRAO,
    parameter int T_ASSENTO  = 25_000_000,
    parameter int T_TIMEOUT  = 1_500_000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ligar,
    input  logic                          modo_continuo,
    input  logic                          fim_medida,
    input  logic [DIST_W-1:0]             medida,
    input  logic                          fim_transmissao,
    output logic                          medir,
    output logic                          transmitir,
    output logic [$clog2(N_POSICOES)-1:0] posicao,
    output logic [DIST_W-1:0]             distancia_min,
    output logic                          timeout,
    output logic                          fim_posicao,
    output logic                          fim_varredura,
    output logic                          ativo,
    output logic [3:0]                    db_estado
);

    localparam int POS_W = $clog2(N_POSICOES);
    localparam logic [POS_W-1:0] POS_ULTIMA    = POS_W'(N_POSICOES - 1);
    localparam logic [POS_W-1:0] POS_PENULTIMA = POS_W'(N_POSICOES - 2);
    localparam logic [DIST_W-1:0] DIST_TOPO    = '1;

    estado_t           estado;
    estado_t           estado_prox;
    logic              sobe;
    logic              stop_pend;
    logic [DIST_W-1:0] amostra;
    logic              fim_assento;
    logic              fim_timer;
    logic              fim_amostras;
    logic              encerra;

    assign encerra = stop_pend || (!modo_continuo && (posicao == POS_ULTIMA));

    contador_m #(.M(T_ASSENTO)) u_assento (
        .clock (clock),
        .reset (reset),
        .zera  (estado == PREPARA),
        .conta (estado == ASSENTA),
        .fim   (fim_assento)
    );

    contador_m #(.M(T_TIMEOUT)) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (estado == MEDE),
        .conta (estado == AGUARDA),
        .fim   (fim_timer)
    );

    contador_m #(.M(N_AMOSTRAS)) u_amostras (
        .clock (clock),
        .reset (reset),
        .zera  (estado == PREPARA),
        .conta (estado == ACUMULA),
        .fim   (fim_amostras)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            INICIAL:    if (ligar) estado_prox = PREPARA;
            PREPARA:    estado_prox = ASSENTA;
            ASSENTA:    if (fim_assento) estado_prox = MEDE;
            MEDE:       estado_prox = AGUARDA;
            AGUARDA:    if (fim_medida || fim_timer) estado_prox = ACUMULA;
            ACUMULA:    estado_prox = fim_amostras ? TRANSMITE : MEDE;
            TRANSMITE:  estado_prox = AGUARDA_TX;
            AGUARDA_TX: if (fim_transmissao) estado_prox = PROXIMA;
            PROXIMA:    estado_prox = encerra ? FIM : PREPARA;
            FIM:        estado_prox = INICIAL;
            default:    estado_prox = INICIAL;
        endcase
    end

    // Datapath: a real measurement in the timeout cycle wins over the timeout sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            posicao       <= '0;
            sobe          <= 1'b1;
            distancia_min <= DIST_TOPO;
            timeout       <= 1'b0;
            amostra       <= DIST_TOPO;
            stop_pend     <= 1'b0;
        end else begin
            if (ligar && (estado != INICIAL) && (estado != FIM)) begin
                stop_pend <= 1'b1;
            end
            case (estado)
                PREPARA: begin
                    distancia_min <= DIST_TOPO;
                    timeout       <= 1'b0;
                end
                AGUARDA: begin
                    if (fim_medida) begin
                        amostra <= medida;
                    end else if (fim_timer) begin
                        amostra <= DIST_TOPO;
                        timeout <= 1'b1;
                    end
                end
                ACUMULA: begin
                    if (amostra < distancia_min) begin
                        distancia_min <= amostra;
                    end
                end
                PROXIMA: begin
                    if (!encerra) begin
                        if (sobe) begin
                            if (posicao == POS_ULTIMA) begin
                                sobe    <= 1'b0;
                                posicao <= POS_PENULTIMA;
                            end else begin
                                posicao <= posicao + POS_W'(1);
                            end
                        end else begin
                            if (posicao == '0) begin
                                sobe    <= 1'b1;
                                posicao <= POS_W'(1);
                            end else begin
                                posicao <= posicao - POS_W'(1);
                            end
                        end
                    end
                end
                FIM: begin
                    posicao   <= '0;
                    sobe      <= 1'b1;
                    stop_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        medir         = (estado == MEDE);
        transmitir    = (estado == TRANSMITE);
        fim_posicao   = (estado == PROXIMA);
        fim_varredura = (estado == FIM);
        ativo         = (estado != INICIAL);
        db_estado     = estado;
    end

endmodule

// File: tb/tb_sonar_varredura_ctrl.sv
// Bench for sonar_varredura_ctrl: emulates the measurement and serial units and scores
// each transmitted minimum against a queue of values predicted from the driven samples.
module tb_sonar_varredura_ctrl;

    import sonar_pkg::*;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int TA = 5;
    localparam int TT = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        modo_continuo;
    logic        fim_medida;
    logic [11:0] medida;
    logic        fim_transmissao;
    logic        medir;
    logic        transmitir;
    logic [1:0]  posicao;
    logic [11:0] distancia_min;
    logic        timeout;
    logic        fim_posicao;
    logic        fim_varredura;
    logic        ativo;
    logic [3:0]  db_estado;

    typedef struct {
        int          pos;
        logic [11:0] dmin;
        logic        tmo;
    } esperado_t;

    esperado_t sb[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int t_prepara = 0;
    int n_tx      = 0;
    int n_fimpos  = 0;
    int n_fimvar  = 0;

    sonar_varredura_ctrl #(
        .N_POSICOES (N),
        .N_AMOSTRAS (S),
        .DIST_W     (12),
        .T_ASSENTO  (TA),
        .T_TIMEOUT  (TT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ligar           (ligar),
        .modo_continuo   (modo_continuo),
        .fim_medida      (fim_medida),
        .medida          (medida),
        .fim_transmissao (fim_transmissao),
        .medir           (medir),
        .transmitir      (transmitir),
        .posicao         (posicao),
        .distancia_min   (distancia_min),
        .timeout         (timeout),
        .fim_posicao     (fim_posicao),
        .fim_varredura   (fim_varredura),
        .ativo           (ativo),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every transmitir pops the prediction made when the samples were driven.
    always @(negedge clock) begin
        esperado_t e;
        if (db_estado == 4'h1) t_prepara = cyc;
        if (transmitir === 1'b1) begin
            n_tx++;
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("tx_posicao", 32'(posicao), 32'(e.pos));
                checkOutput("tx_dmin", 32'(distancia_min), 32'(e.dmin));
                checkOutput("tx_timeout", 32'(timeout), 32'(e.tmo));
            end
        end
        if (fim_posicao === 1'b1) n_fimpos++;
        if (fim_varredura === 1'b1) n_fimvar++;
    end

    task automatic pulseLigar();
        @(negedge clock);
        ligar = 1'b1;
        @(negedge clock);
        ligar = 1'b0;
    endtask

    // One servo position: d=0 means the sample is never answered; d is the reply delay
    // in cycles after medir, d==TT lands exactly on the timeout cycle.
    task automatic applyStimulus(input int exp_pos, input logic [11:0] m0, input logic [11:0] m1,
                                 input int d0, input int d1, input bit stop_req, input bit tx_resp);
        logic [11:0] exp_min;
        logic [11:0] smp;
        logic        exp_tmo;
        bit          found;
        bit          prev_to;
        int          t_prev;
        int          d;
        int          esperou;
        exp_min = 12'hFFF;
        exp_tmo = 1'b0;
        prev_to = 1'b0;
        t_prev  = 0;
        for (int s = 0; s < S; s++) begin
            d = (s == 0) ? d0 : d1;
            found = 1'b0;
            for (int k = 0; k < 200 && !found; k++) begin
                @(negedge clock);
                if (medir === 1'b1) found = 1'b1;
            end
            checkOutput("medir_seen", 32'(found), 32'd1);
            if (!found) return;
            if (s == 0) checkOutput("settle_latency", 32'(cyc - t_prepara), 32'(TA + 1));
            else if (prev_to) checkOutput("timeout_reissue", 32'(cyc - t_prev), 32'(TT + 2));
            t_prev = cyc;
            smp = (d == 0) ? 12'hFFF : ((s == 0) ? m0 : m1);
            if (d == 0) exp_tmo = 1'b1;
            if (smp < exp_min) exp_min = smp;
            prev_to = (d == 0);
            if (s == S - 1) sb.push_back('{exp_pos, exp_min, exp_tmo});
            esperou = 0;
            if (stop_req && s == 0) begin
                @(negedge clock);
                ligar = 1'b1;
                @(negedge clock);
                ligar = 1'b0;
                esperou = 2;
            end
            if (d != 0) begin
                repeat (d - esperou) @(negedge clock);
                medida     = (s == 0) ? m0 : m1;
                fim_medida = 1'b1;
                @(negedge clock);
                fim_medida = 1'b0;
            end
        end
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clock);
            if (transmitir === 1'b1) found = 1'b1;
        end
        checkOutput("transmitir_seen", 32'(found), 32'd1);
        if (found && tx_resp) begin
            @(negedge clock);
            @(negedge clock);
            fim_transmissao = 1'b1;
            @(negedge clock);
            fim_transmissao = 1'b0;
        end
    endtask

    task automatic checkSweepEnd(input string tag, input int exp_pos);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (fim_posicao === 1'b1) found = 1'b1;
            else @(negedge clock);
        end
        checkOutput({tag, "_fim_posicao"}, 32'(found), 32'd1);
        checkOutput({tag, "_pos_last"}, 32'(posicao), 32'(exp_pos));
        @(negedge clock);
        checkOutput({tag, "_fim_varredura"}, 32'(fim_varredura), 32'd1);
        checkOutput({tag, "_estado_fim"}, 32'(db_estado), 32'hF);
        @(negedge clock);
        checkOutput({tag, "_estado_ini"}, 32'(db_estado), 32'h0);
        checkOutput({tag, "_ativo"}, 32'(ativo), 32'd0);
        checkOutput({tag, "_pos_zero"}, 32'(posicao), 32'd0);
        checkOutput({tag, "_fv_pulse"}, 32'(fim_varredura), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_estado"}, 32'(db_estado), 32'h0);
        checkOutput({tag, "_ativo"}, 32'(ativo), 32'd0);
        checkOutput({tag, "_posicao"}, 32'(posicao), 32'd0);
        checkOutput({tag, "_dmin"}, 32'(distancia_min), 32'(DIST_MAX));
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
        checkOutput({tag, "_pulses"}, 32'({medir, transmitir, fim_posicao, fim_varredura}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seq1 [8];
        seq1 = '{0, 1, 2, 3, 2, 1, 0, 1};
        reset           = 1'b1;
        ligar           = 1'b0;
        modo_continuo   = 1'b0;
        fim_medida      = 1'b0;
        medida          = 12'h000;
        fim_transmissao = 1'b0;
        repeat (3) @(negedge clock);
        checkResetState("rst");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] continuous ping-pong sweep");
        modo_continuo = 1'b1;
        n_tx = 0; n_fimpos = 0; n_fimvar = 0;
        pulseLigar();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(seq1[i], 12'h120, 12'h085, 3, 3, (i == 7), 1'b1);
        end
        checkSweepEnd("t1", 1);
        checkOutput("t1_n_tx", 32'(n_tx), 32'd8);
        checkOutput("t1_n_fimpos", 32'(n_fimpos), 32'd8);
        checkOutput("t1_n_fimvar", 32'(n_fimvar), 32'd1);

        $display("[TB] single sweep with timeouts");
        modo_continuo = 1'b0;
        n_tx = 0; n_fimpos = 0; n_fimvar = 0;
        pulseLigar();
        applyStimulus(0, 12'h300, 12'h250, 3, 4, 1'b0, 1'b1);
        applyStimulus(1, 12'h111, 12'h222, 0, 5, 1'b0, 1'b1);
        applyStimulus(2, 12'h400, 12'h050, 2, TT, 1'b0, 1'b1);
        applyStimulus(3, 12'h010, 12'h020, 0, 0, 1'b0, 1'b1);
        checkSweepEnd("t2", 3);
        repeat (TA + 10) @(negedge clock);
        checkOutput("t2_n_tx", 32'(n_tx), 32'd4);
        checkOutput("t2_n_fimpos", 32'(n_fimpos), 32'd4);
        checkOutput("t2_n_fimvar", 32'(n_fimvar), 32'd1);

        $display("[TB] stop request at position 2");
        modo_continuo = 1'b1;
        n_tx = 0; n_fimpos = 0; n_fimvar = 0;
        pulseLigar();
        applyStimulus(0, 12'h500, 12'h600, 3, 3, 1'b0, 1'b1);
        applyStimulus(1, 12'h777, 12'h700, 3, 3, 1'b0, 1'b1);
        applyStimulus(2, 12'h045, 12'h046, 3, 3, 1'b1, 1'b1);
        checkSweepEnd("t4", 2);
        checkOutput("t4_n_tx", 32'(n_tx), 32'd3);
        checkOutput("t4_n_fimvar", 32'(n_fimvar), 32'd1);

        $display("[TB] reset while waiting for the serial frame");
        modo_continuo = 1'b0;
        n_tx = 0; n_fimpos = 0; n_fimvar = 0;
        pulseLigar();
        applyStimulus(0, 12'h123, 12'h321, 3, 3, 1'b0, 1'b1);
        applyStimulus(1, 12'h0AA, 12'h0BB, 3, 3, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("t5_in_aguarda_tx", 32'(db_estado), 32'h7);
        reset = 1'b1;
        @(negedge clock);
        checkResetState("t5");
        reset = 1'b0;
        @(negedge clock);
        fim_transmissao = 1'b1;
        @(negedge clock);
        fim_transmissao = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("t5_late_tx_ignored", 32'(db_estado), 32'h0);
        checkOutput("t5_n_fimpos", 32'(n_fimpos), 32'd1);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
